// File: rtl/bus_copy_master.sv
// -----------------------------------------------------------------------------
// bus_copy_master
//
// Bus initiator for the single-master BUS interconnect. Copies a block of
// `len` DATA_W-bit words from src_addr to dst_addr, one read followed by one
// write per word, in ascending address order. All outputs are registered.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   start      in   1       command strobe, only looked at while idle
//   src_addr   in   ADDR_W  first source word address
//   dst_addr   in   ADDR_W  first destination word address
//   len        in   LEN_W   number of words to copy (0 = immediate done)
//   busy       out  1       high from the cycle after an accepted start through the done cycle
//   done       out  1       one-cycle completion pulse
//   m_req      out  1       bus request to arbiter
//   m_grant    in   1       bus grant from arbiter
//   m_wr       out  1       1 = write, 0 = read
//   m_addr     out  ADDR_W  bus address
//   m_dout     out  DATA_W  write data
//   m_din      in   DATA_W  read data, valid the cycle after the read address
//
// Optional feature (macro BUS_COPY_MASTER_FILL_EN):
//   fill       in   1       1 = write fill_data to every destination word, no reads
//   fill_data  in   DATA_W  pattern to write; sampled together with start
// -----------------------------------------------------------------------------
module bus_copy_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef BUS_COPY_MASTER_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    index_q;
    logic [LEN_W-1:0]    index_d;
    logic [DATA_W-1:0]   buf_q;
    logic                busy_q;
    logic                done_q;
    logic                m_req_q;
    logic                m_wr_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_dout_q;
`ifdef BUS_COPY_MASTER_FILL_EN
    logic                fill_q;
`endif

    // Word index after the current write retires.
    assign index_d = index_q + LEN_W'(1);

    // NOTE: all state lives in one clocked block and uses non-blocking
    // assignments, so every branch reads the pre-edge value of every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            index_q  <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            m_req_q  <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= '0;
            m_dout_q <= '0;
`ifdef BUS_COPY_MASTER_FILL_EN
            fill_q   <= 1'b0;
`endif
        end else begin
            // done is a pulse: only the transition into DONE raises it.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            src_q   <= src_addr;
                            dst_q   <= dst_addr;
                            len_q   <= len;
                            index_q <= '0;
                            m_req_q <= 1'b1;
                            state_q <= S_REQ;
`ifdef BUS_COPY_MASTER_FILL_EN
                            fill_q  <= fill;
                            if (fill) buf_q <= fill_data;
`endif
                        end else begin
                            // Empty command completes without touching the bus.
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    if (m_grant) begin
`ifdef BUS_COPY_MASTER_FILL_EN
                        if (fill_q) begin
                            m_wr_q   <= 1'b1;
                            m_addr_q <= dst_q;
                            m_dout_q <= buf_q;
                            state_q  <= S_WRITE;
                        end else begin
                            m_addr_q <= src_q;
                            state_q  <= S_READ;
                        end
`else
                        m_addr_q <= src_q;
                        state_q  <= S_READ;
`endif
                    end
                end

                // Read address is on the bus; without grant everything holds.
                S_READ: begin
                    if (m_grant) state_q <= S_CAPT;
                end

                // The slave select is registered, so data for the address
                // issued in READ arrives now, regardless of grant.
                S_CAPT: begin
                    buf_q    <= m_din;
                    m_wr_q   <= 1'b1;
                    m_addr_q <= dst_q + ADDR_W'(index_q);
                    m_dout_q <= m_din;
                    state_q  <= S_WRITE;
                end

                S_WRITE: begin
                    if (m_grant) begin
                        index_q <= index_d;
                        if (index_d == len_q) begin
                            done_q   <= 1'b1;
                            m_req_q  <= 1'b0;
                            m_wr_q   <= 1'b0;
                            m_addr_q <= '0;
                            m_dout_q <= '0;
                            state_q  <= S_DONE;
`ifdef BUS_COPY_MASTER_FILL_EN
                        end else if (fill_q) begin
                            m_addr_q <= dst_q + ADDR_W'(index_d);
`endif
                        end else begin
                            m_wr_q   <= 1'b0;
                            m_addr_q <= src_q + ADDR_W'(index_d);
                            m_dout_q <= '0;
                            state_q  <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign m_req  = m_req_q;
    assign m_wr   = m_wr_q;
    assign m_addr = m_addr_q;
    assign m_dout = m_dout_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// -----------------------------------------------------------------------------
// tb_bus_copy_master
//
// Drives bus_copy_master against a registered-read bus slave and checks the
// resulting memory image, write order, handshake timing and status outputs
// against a word-level model of the block copy.
// -----------------------------------------------------------------------------
module tb_bus_copy_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_grant;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] m_din;
`ifdef BUS_COPY_MASTER_FILL_EN
    logic        fill;
    logic [63:0] fill_data;
`endif

    logic        drop;       // forces the arbiter to withhold grant
    logic        mem_init;   // slave fills its memory with random words
    logic [63:0] mem     [0:65535];
    logic [63:0] ref_mem [0:65535];

    int n_cmp;
    int n_bad;

    bus_copy_master dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
`ifdef BUS_COPY_MASTER_FILL_EN
        .fill     (fill),
        .fill_data(fill_data),
`endif
        .busy     (busy),
        .done     (done),
        .m_req    (m_req),
        .m_grant  (m_grant),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_din    (m_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-master arbiter: grant follows request unless a drop is forced.
    assign m_grant = m_req & ~drop;

    // Bus slave: writes on granted write cycles, read data registered one
    // cycle after the address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= {$urandom, $urandom};
        end else begin
            if (m_req && m_wr && m_grant) mem[m_addr] <= m_dout;
            if (m_req && !m_wr) m_din <= mem[m_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {63'd0, busy, done, m_req, m_wr, m_addr, m_dout}, '0);
    endtask

    task automatic check_memory(input string tag);
        int diffs = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, 64'(diffs), 64'd0);
    endtask

    // One complete command. Expected write stream and final memory come from
    // the word-level model; timing from the cycles-per-word rule.
    task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                            input logic [7:0] n, input int drop_word, input bit poke,
                            input bit f, input logic [63:0] fd);
        logic [63:0] wvals[$];
        logic [15:0] a;
        logic [63:0] v;
        int t, t0, td, writes, reads, gaps, wr_bad, held_bad, drop_left, extra;
        bit dropped;

        for (int i = 0; i < int'(n); i++) begin
            a = s + 16'(i);
            v = f ? fd : ref_mem[a];
            wvals.push_back(v);
            a = d + 16'(i);
            ref_mem[a] = v;
        end

        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
`ifdef BUS_COPY_MASTER_FILL_EN
        fill = f; fill_data = fd;
`endif
        @(negedge clk);
        // Scramble command inputs: the block must work from its latched copy.
        start = 1'b0; src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom);
`ifdef BUS_COPY_MASTER_FILL_EN
        fill = ~f; fill_data = {$urandom, $urandom};
`endif
        t = 0; t0 = -1; td = -1; writes = 0; reads = 0; gaps = 0; wr_bad = 0;
        held_bad = 0; drop_left = 0; dropped = 1'b0; extra = 0;

        while (td < 0 && t < 3 * int'(n) + 60) begin
            if (done) begin
                td = t;
            end else begin
                if (!busy || !m_req) gaps++;
                if (drop_left > 0) begin
                    a = d + 16'(drop_word);
                    if (m_addr !== a || m_dout !== wvals[drop_word] || !m_wr) held_bad++;
                    drop_left--;
                    if (drop_left == 0) drop = 1'b0;
                end else if (drop_word >= 0 && !dropped && m_wr && m_addr == 16'(d + 16'(drop_word))) begin
                    drop = 1'b1; drop_left = 3; dropped = 1'b1; extra = 3;
                end
                if (t0 < 0 && m_req && !drop) t0 = t;
                if (m_req && !m_wr) reads++;
                if (m_req && m_wr && !drop) begin
                    a = d + 16'(writes);
                    if (writes >= int'(n) || m_addr !== a || m_dout !== wvals[writes]) wr_bad++;
                    writes++;
                end
                start = poke && t == 2;
                if (start) begin
                    src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom_range(1, 255));
                end
            end
            if (td < 0) begin
                @(negedge clk);
                t++;
            end
        end
        start = 1'b0;
        drop  = 1'b0;

        check({tag, " done_seen"}, 64'(td >= 0), 64'd1);
        if (n == 0) begin
            check({tag, " done_latency"}, 64'(td), 64'd0);
            check({tag, " no_bus_traffic"}, 64'(reads + writes + gaps), 64'(gaps));
        end else begin
            check({tag, " done_latency"}, 64'(td - t0),
                  64'(1 + (f ? 1 : 3) * int'(n) + extra));
            check({tag, " write_count"}, 64'(writes), 64'(n));
            check({tag, " write_stream"}, 64'(wr_bad), 64'd0);
            check({tag, " read_cycles"}, 64'(reads), 64'(f ? 1 : 1 + 2 * int'(n)));
            check({tag, " req_busy_gaps"}, 64'(gaps), 64'd0);
            if (drop_word >= 0) check({tag, " held_during_drop"}, 64'(held_bad), 64'd0);
        end
        // DONE cycle: status high, bus quiet. A start here must be ignored.
        check({tag, " done_cycle"}, {58'd0, busy, done, m_req, m_wr, 2'b00} | 64'(m_addr) | m_dout, 64'h30);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " back_to_idle"}, {62'd0, busy, done}, 64'd0);
        check_memory({tag, " memory"});
    endtask

    initial begin
        logic [63:0] v;
        int seen_done;

        n_cmp = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        drop = 1'b0; mem_init = 1'b1;
`ifdef BUS_COPY_MASTER_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        @(posedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        check_idle_outputs("reset_state");
        reset = 1'b0;

        // Directed block copy with grant tied to request.
        run_copy("copy4", 16'h0000, 16'h0100, 8'd4, -1, 1'b0, 1'b0, '0);
        v = ref_mem[16'h0003];
        check("copy4 word3_value", mem[16'h0103], v);

        // Empty command: done next cycle, no request.
        run_copy("len0", 16'h1234, 16'h5678, 8'd0, -1, 1'b0, 1'b0, '0);

        // Source crosses the top of the address space.
        run_copy("wrap", 16'hFFFF, 16'h0200, 8'd2, -1, 1'b0, 1'b0, '0);
        v = ref_mem[16'h0000];
        check("wrap word1_value", mem[16'h0201], v);

        // Grant withdrawn for 3 cycles during word 1 write; start poked mid-block.
        run_copy("grant_drop", 16'h0800, 16'h0900, 8'd4, 1, 1'b1, 1'b0, '0);

        // Reset in the fifth cycle of a 4-word copy, then rerun the same copy.
        @(negedge clk);
        start = 1'b1; src_addr = 16'h0400; dst_addr = 16'h0500; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int t = 0; t < 4; t++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        if (done) seen_done++;
        check_idle_outputs("abort outputs_cleared");
        reset = 1'b0;
        @(negedge clk);
        if (done) seen_done++;
        check("abort no_done_pulse", 64'(seen_done), 64'd0);
        run_copy("after_abort", 16'h0400, 16'h0500, 8'd4, -1, 1'b0, 1'b0, '0);

`ifdef BUS_COPY_MASTER_FILL_EN
        run_copy("fill3", 16'h0000, 16'h0300, 8'd3, -1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        run_copy("fill_drop", 16'h0000, 16'h0310, 8'd5, 2, 1'b0, 1'b1, {$urandom, $urandom});
`endif

        // Random commands, overlapping ranges allowed, occasional grant drops.
        for (int k = 0; k < 8; k++) begin
            logic [15:0] s, d;
            logic [7:0]  n;
            int dw;
            s  = 16'($urandom);
            d  = (k % 2 == 0) ? s + 16'($urandom_range(0, 6)) : 16'($urandom);
            n  = 8'($urandom_range(1, 20));
            dw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(n) - 1)) : -1;
            run_copy($sformatf("rand%0d", k), s, d, n, dw, k % 3 == 0, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
